// File: rtl/alvio_ram_cfg.sv
// alvio_ram_cfg: active-list violation RAM.
// Multi-port write / combinational multi-lane read storage, split into
// power-gateable partitions. A sequential clear engine zeroes one row of
// every partition per cycle and replaces a full-array reset. ready_o is
// a level-style status flag, not a handshake: 1 means the array is fully
// cleared and user reads/writes are honoured; 0 means the clear engine
// owns the array (writes dropped, every read lane returns 0).
module alvio_ram_cfg #(
  parameter int RPORT     = 4,
  parameter int WPORT     = 2,
  parameter int DEPTH     = 16,
  parameter int INDEX     = 4,
  parameter int WIDTH     = 8,
  parameter int NUM_PARTS = 4,
  parameter int PART_LOG  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RPORT*INDEX-1:0] addr_i,
  output logic [RPORT*WIDTH-1:0] data_o,
  input  logic [WPORT*INDEX-1:0] addrWr_i,
  input  logic [WPORT*WIDTH-1:0] dataWr_i,
  input  logic [WPORT-1:0]       we_i,
  input  logic [RPORT-1:0]       readLaneActive_i,
  input  logic [NUM_PARTS-1:0]   partActive_i,
  input  logic                   flush_i,
  output logic                   ready_o,
  output logic                   state_dbg_o
);

  localparam int ROWS  = DEPTH / NUM_PARTS;
  localparam int ROW_W = INDEX - PART_LOG;
  localparam int CNT_W = (ROW_W > 0) ? ROW_W : 1;
  localparam int PW    = (PART_LOG > 0) ? PART_LOG : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PARTS-1:0] part_act_q, part_act_d;
  logic [WIDTH-1:0]     ram_q [DEPTH];
  logic [WIDTH-1:0]     ram_d [DEPTH];

  // Per-port decoded views, kept as named signals so checkers can bind.
  logic [WPORT-1:0]     wr_ok;
  logic [RPORT-1:0]     rd_ok;
  logic                 part_rise;
  logic                 clear_req;

  // Partition number is the top PART_LOG address bits.
  function automatic logic [PW-1:0] part_of(input logic [INDEX-1:0] a);
    part_of = PW'(a >> ROW_W);
  endfunction

  // A partition coming back from gating holds garbage, so a 0->1 edge on
  // any partActive_i bit forces a full clear just like flush_i does.
  always_comb begin
    part_rise  = |(partActive_i & ~part_act_q);
    clear_req  = flush_i | part_rise;
    part_act_d = partActive_i;
  end

  // Clear-engine FSM: next state and row counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (clear_req) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ROW) begin
          // Last row is written on this edge; counter is held, not wrapped.
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READY: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, row counter and registered partition-enable copy.
  // The enable copy resets to all ones so that partitions already active
  // at reset release do not look like a rising edge and restart the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      part_act_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      part_act_q <= part_act_d;
    end
  end

  // Write qualification: READY only, and the target partition powered.
  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < WPORT; w++) begin
      wr_ok[w] = (state_q == S_READY) && we_i[w] &&
                 partActive_i[part_of(addrWr_i[w*INDEX +: INDEX])];
    end
  end

  // Next array contents: clear one row per partition, or apply user
  // writes in ascending port order so the highest port wins a conflict.
  always_comb begin
    ram_d = ram_q;
    if (state_q == S_CLEAR) begin
      for (int p = 0; p < NUM_PARTS; p++) begin
        ram_d[INDEX'(p * ROWS) + INDEX'(cnt_q)] = '0;
      end
    end else begin
      for (int w = 0; w < WPORT; w++) begin
        if (wr_ok[w]) begin
          ram_d[addrWr_i[w*INDEX +: INDEX]] = dataWr_i[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Storage array is deliberately not reset; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    ram_q <= ram_d;
  end

  // Combinational reads, forced to 0 for gated lanes/partitions or CLEAR.
  always_comb begin
    data_o = '0;
    rd_ok  = '0;
    for (int k = 0; k < RPORT; k++) begin
      rd_ok[k] = (state_q == S_READY) && readLaneActive_i[k] &&
                 partActive_i[part_of(addr_i[k*INDEX +: INDEX])];
      if (rd_ok[k]) begin
        data_o[k*WIDTH +: WIDTH] = ram_q[addr_i[k*INDEX +: INDEX]];
      end
    end
  end

  // Status outputs follow the state register, so an asynchronous reset
  // drops ready_o immediately.
  always_comb begin
    ready_o     = (state_q == S_READY);
    state_dbg_o = state_q;
  end

endmodule

// File: tb/tb_alvio_ram_cfg.sv
// Directed self-checking bench for alvio_ram_cfg (default parameters).
module tb_alvio_ram_cfg;

  logic        clk;
  logic        reset;
  logic [15:0] addr_i;
  logic [31:0] data_o;
  logic [7:0]  addrWr_i;
  logic [15:0] dataWr_i;
  logic [1:0]  we_i;
  logic [3:0]  readLaneActive_i;
  logic [3:0]  partActive_i;
  logic        flush_i;
  logic        ready_o;
  logic        state_dbg_o;

  int checks;
  int errors;

  alvio_ram_cfg dut (
    .clk              (clk),
    .reset            (reset),
    .addr_i           (addr_i),
    .data_o           (data_o),
    .addrWr_i         (addrWr_i),
    .dataWr_i         (dataWr_i),
    .we_i             (we_i),
    .readLaneActive_i (readLaneActive_i),
    .partActive_i     (partActive_i),
    .flush_i          (flush_i),
    .ready_o          (ready_o),
    .state_dbg_o      (state_dbg_o)
  );

  // Clock: 10 time-unit period, rising edge active.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  // Advance past one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd_all(input logic [3:0] a);
    addr_i = {a, a, a, a};
  endtask

  task automatic set_wr(input int port, input logic [3:0] a, input logic [7:0] d);
    addrWr_i[port*4 +: 4] = a;
    dataWr_i[port*8 +: 8] = d;
    we_i[port]            = 1'b1;
  endtask

  task automatic clr_wr();
    we_i = 2'b00;
  endtask

  function automatic logic [7:0] lane(input int k);
    lane = data_o[k*8 +: 8];
  endfunction

  // Expect ready_o low at the current point and for the next n-1 edges,
  // then high after the n-th edge.
  task automatic expect_clear(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s: ready_o before clear edge %0d = %b, expected 0", name, i + 1, ready_o);
      end
      step();
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: ready_o after %0d clear edges = %b, expected 1", name, n, ready_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (ready_o !== 1'b0 || data_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold: ready_o=%b data_o=%h, expected 0 and 0", ready_o, data_o);
      end
    end
    reset = 1'b1;
    expect_clear("reset_clear", 4);
    for (int a = 0; a < 16; a++) begin
      rd_all(4'(a));
      #1;
      checks++;
      if (data_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_zero: addr %0d data_o=%h, expected 00000000", a, data_o);
      end
    end
  endtask

  task automatic test_write_read();
    set_wr(0, 4'd3, 8'hA5);
    addr_i[8 +: 4] = 4'd3;
    #1;
    checks++;
    if (lane(2) !== 8'h00) begin
      errors++;
      $display("FAIL same_cycle_read: lane2 addr3=%h, expected 00", lane(2));
    end
    step();
    clr_wr();
    #1;
    checks++;
    if (lane(2) !== 8'hA5) begin
      errors++;
      $display("FAIL write_read: lane2 addr3=%h, expected a5", lane(2));
    end
    set_wr(0, 4'd7, 8'h11);
    set_wr(1, 4'd7, 8'h22);
    step();
    clr_wr();
    rd_all(4'd7);
    #1;
    checks++;
    if (lane(0) !== 8'h22) begin
      errors++;
      $display("FAIL port_conflict: addr7=%h, expected 22", lane(0));
    end
  endtask

  task automatic test_part_gating();
    set_wr(1, 4'd9, 8'h5A);
    step();
    clr_wr();
    rd_all(4'd9);
    #1;
    checks++;
    if (lane(1) !== 8'h5A) begin
      errors++;
      $display("FAIL gate_pre: addr9=%h, expected 5a", lane(1));
    end
    partActive_i[2] = 1'b0;
    #1;
    checks++;
    if (lane(1) !== 8'h00) begin
      errors++;
      $display("FAIL gate_read: addr9 gated=%h, expected 00", lane(1));
    end
    set_wr(0, 4'd10, 8'hFF);
    step();
    clr_wr();
    rd_all(4'd3);
    #1;
    checks++;
    if (lane(3) !== 8'hA5) begin
      errors++;
      $display("FAIL gate_other_part: addr3=%h, expected a5", lane(3));
    end
    partActive_i[2] = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL gate_reenable_pre: ready_o=%b, expected 1", ready_o);
    end
    step();
    expect_clear("gate_reclear", 4);
    rd_all(4'd9);
    #1;
    checks++;
    if (lane(0) !== 8'h00) begin
      errors++;
      $display("FAIL gate_after: addr9=%h, expected 00", lane(0));
    end
    rd_all(4'd10);
    #1;
    checks++;
    if (lane(0) !== 8'h00) begin
      errors++;
      $display("FAIL gate_dropped_wr: addr10=%h, expected 00", lane(0));
    end
  endtask

  task automatic test_lane_gating();
    set_wr(1, 4'd5, 8'h3C);
    step();
    clr_wr();
    rd_all(4'd5);
    readLaneActive_i = 4'b0101;
    #1;
    checks++;
    if (data_o !== 32'h003C_003C) begin
      errors++;
      $display("FAIL lane_gating: data_o=%h, expected 003c003c", data_o);
    end
    readLaneActive_i = 4'b1111;
    #1;
    checks++;
    if (data_o !== 32'h3C3C_3C3C) begin
      errors++;
      $display("FAIL lane_all: data_o=%h, expected 3c3c3c3c", data_o);
    end
  endtask

  task automatic test_flush_during_clear();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    rd_all(4'd5);
    #1;
    checks++;
    if (ready_o !== 1'b0 || data_o !== 32'h0) begin
      errors++;
      $display("FAIL flush_enter: ready_o=%b data_o=%h, expected 0 and 0", ready_o, data_o);
    end
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ready_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_restart: ready_o after restart+%0d = %b, expected 0", i, ready_o);
      end
      if (i == 3) set_wr(0, 4'd6, 8'h77);
      step();
      clr_wr();
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: ready_o=%b, expected 1", ready_o);
    end
    rd_all(4'd6);
    #1;
    checks++;
    if (lane(2) !== 8'h00) begin
      errors++;
      $display("FAIL clear_wr_ignored: addr6=%h, expected 00", lane(2));
    end
  endtask

  task automatic test_async_reset();
    set_wr(0, 4'd1, 8'h99);
    step();
    clr_wr();
    rd_all(4'd1);
    #2;
    checks++;
    if (ready_o !== 1'b1 || lane(0) !== 8'h99) begin
      errors++;
      $display("FAIL async_pre: ready_o=%b addr1=%h, expected 1 and 99", ready_o, lane(0));
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || data_o !== 32'h0) begin
      errors++;
      $display("FAIL async_drop: ready_o=%b data_o=%h, expected 0 and 0", ready_o, data_o);
    end
    step();
    reset = 1'b1;
    expect_clear("async_reclear", 4);
    #1;
    checks++;
    if (lane(0) !== 8'h00) begin
      errors++;
      $display("FAIL async_cleared: addr1=%h, expected 00", lane(0));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b0;
    addr_i           = '0;
    addrWr_i         = '0;
    dataWr_i         = '0;
    we_i             = '0;
    readLaneActive_i = 4'b1111;
    partActive_i     = 4'b1111;
    flush_i          = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_part_gating();
    test_lane_gating();
    test_flush_during_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
